// File: rtl/dp_decode_if.sv
// dp_decode_if - instruction handshake between the fetch side and dp_decode.
//   instr        32  instruction word
//   instr_valid   1  instr is valid
//   instr_ready   1  dp_decode accepts instr this cycle
// master = instruction source, slave = dp_decode.
interface dp_decode_if;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;

   modport master (output instr, output instr_valid, input instr_ready);
   modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/dp_decode.sv
// dp_decode - decode/sequencing stage for ARM-format data-processing instructions.
// Sequence: IDLE (accept) -> DECODE (read operands, check cond) -> EXEC (one-hot
// unit enable) -> WB (write Rd, update NZCV). One instruction per 4 cycles.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ifc (dp_decode_if.slave)  instr / instr_valid / instr_ready handshake
//   rf_raddr_n/m, rf_rdata_n/m  register-file read port (combinational data)
//   IMM, S, Rn, Rm, imm_operand, imm_shift, stype  registered operand fields
//   carry_in, zero_in, neg_in current C/Z/N
//   en_inst                   one-hot ALU unit enable (EXEC only)
//   res_rd, res_carry/zero/neg/ovf  selected unit result, sampled in WB
//   rf_we, rf_waddr, rf_wdata write-back port (WB only)
//   flag_n/z/c/v              NZCV register
//   undef                     pulse while an illegal encoding sits in DECODE
//   busy                      not in IDLE
// Build option: define DP_DECODE_COND_EN to evaluate the condition field and
// reject cond=1111; otherwise every legal instruction executes as AL.
module dp_decode (
   input  logic        clk,
   input  logic        rst,
   dp_decode_if.slave  ifc,
   output logic [3:0]  rf_raddr_n,
   output logic [3:0]  rf_raddr_m,
   input  logic [31:0] rf_rdata_n,
   input  logic [31:0] rf_rdata_m,
   output logic        IMM,
   output logic        S,
   output logic [31:0] Rn,
   output logic [31:0] Rm,
   output logic [11:0] imm_operand,
   output logic [4:0]  imm_shift,
   output logic [1:0]  stype,
   output logic        carry_in,
   output logic        zero_in,
   output logic        neg_in,
   output logic [15:0] en_inst,
   input  logic [31:0] res_rd,
   input  logic        res_carry,
   input  logic        res_zero,
   input  logic        res_neg,
   input  logic        res_ovf,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        flag_n,
   output logic        flag_z,
   output logic        flag_c,
   output logic        flag_v,
   output logic        undef,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   state_t      state;
   logic [25:0] ir;          // latched [25:0]; cond is kept separately
   logic        illegal_in;  // illegality of the word being offered
   logic        cond_pass;
   logic [3:0]  opcode;
   logic        is_cmp;      // TST/TEQ/CMP/CMN: flags only, no write-back
   logic        is_arith;    // opcodes whose V comes from the unit

   assign opcode   = ir[24:21];
   assign is_cmp   = (opcode[3:2] == 2'b10);
   assign is_arith = opcode inside {[4'd2:4'd7], 4'd10, 4'd11};

   assign ifc.instr_ready = (state == IDLE) && !rst;
   assign busy            = (state != IDLE);

   assign rf_raddr_n = ir[19:16];
   assign rf_raddr_m = ir[3:0];
   assign rf_waddr   = ir[15:12];
   assign rf_wdata   = res_rd;

   assign carry_in = flag_c;
   assign zero_in  = flag_z;
   assign neg_in   = flag_n;

`ifdef DP_DECODE_COND_EN
   logic [3:0] cond_r;

   always_comb begin
      illegal_in = (ifc.instr[27:26] != 2'b00) || (!ifc.instr[25] && ifc.instr[4])
                   || (ifc.instr[31:28] == 4'hF);
   end

   always_comb begin
      cond_pass = 1'b0;
      case (cond_r)
         4'h0: cond_pass = flag_z;
         4'h1: cond_pass = !flag_z;
         4'h2: cond_pass = flag_c;
         4'h3: cond_pass = !flag_c;
         4'h4: cond_pass = flag_n;
         4'h5: cond_pass = !flag_n;
         4'h6: cond_pass = flag_v;
         4'h7: cond_pass = !flag_v;
         4'h8: cond_pass = flag_c && !flag_z;
         4'h9: cond_pass = !flag_c || flag_z;
         4'hA: cond_pass = (flag_n == flag_v);
         4'hB: cond_pass = (flag_n != flag_v);
         4'hC: cond_pass = !flag_z && (flag_n == flag_v);
         4'hD: cond_pass = flag_z || (flag_n != flag_v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;  // 1111 never reaches here (illegal)
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cond_r <= 4'h0;
      else if (state == IDLE && ifc.instr_valid)
         cond_r <= ifc.instr[31:28];
   end
`else
   logic unused_cond;
   assign unused_cond = ^ifc.instr[31:28];

   always_comb begin
      illegal_in = (ifc.instr[27:26] != 2'b00) || (!ifc.instr[25] && ifc.instr[4]);
   end

   assign cond_pass = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ir          <= '0;
         undef       <= 1'b0;
         IMM         <= 1'b0;
         S           <= 1'b0;
         Rn          <= '0;
         Rm          <= '0;
         imm_operand <= '0;
         imm_shift   <= '0;
         stype       <= '0;
         en_inst     <= '0;
         rf_we       <= 1'b0;
         flag_n      <= 1'b0;
         flag_z      <= 1'b0;
         flag_c      <= 1'b0;
         flag_v      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               undef <= 1'b0;
               if (ifc.instr_valid) begin
                  ir    <= ifc.instr[25:0];
                  // Legality is known at accept, so undef is already high in DECODE.
                  undef <= illegal_in;
                  state <= DECODE;
               end
            end
            DECODE: begin
               undef       <= 1'b0;
               Rn          <= rf_rdata_n;
               Rm          <= rf_rdata_m;
               IMM         <= ir[25];
               S           <= ir[20];
               imm_operand <= ir[11:0];
               imm_shift   <= ir[11:7];
               stype       <= ir[6:5];
               if (undef || !cond_pass) begin
                  state <= IDLE;
               end else begin
                  en_inst <= 16'd1 << opcode;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               en_inst <= '0;
               rf_we   <= !is_cmp;
               state   <= WB;
            end
            WB: begin
               rf_we <= 1'b0;
               if (S || is_cmp) begin
                  flag_n <= res_neg;
                  flag_z <= res_zero;
                  flag_c <= res_carry;
                  if (is_arith)
                     flag_v <= res_ovf;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dp_decode.sv
module tb_dp_decode;

`ifdef DP_DECODE_COND_EN
   localparam bit COND_EN = 1'b1;
`else
   localparam bit COND_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dp_decode_if ifc ();

   logic [3:0]  rf_raddr_n, rf_raddr_m, rf_waddr;
   logic [31:0] rf_rdata_n, rf_rdata_m, Rn, Rm, res_rd, rf_wdata;
   logic        IMM, S, carry_in, zero_in, neg_in, rf_we;
   logic [11:0] imm_operand;
   logic [4:0]  imm_shift;
   logic [1:0]  stype;
   logic [15:0] en_inst;
   logic        res_carry, res_zero, res_neg, res_ovf;
   logic        flag_n, flag_z, flag_c, flag_v, undef, busy;

   logic [31:0] rf [16];   // bench-side register file
   assign rf_rdata_n = rf[rf_raddr_n];
   assign rf_rdata_m = rf[rf_raddr_m];

   dp_decode dut (
      .clk(clk), .rst(rst), .ifc(ifc),
      .rf_raddr_n(rf_raddr_n), .rf_raddr_m(rf_raddr_m),
      .rf_rdata_n(rf_rdata_n), .rf_rdata_m(rf_rdata_m),
      .IMM(IMM), .S(S), .Rn(Rn), .Rm(Rm),
      .imm_operand(imm_operand), .imm_shift(imm_shift), .stype(stype),
      .carry_in(carry_in), .zero_in(zero_in), .neg_in(neg_in),
      .en_inst(en_inst),
      .res_rd(res_rd), .res_carry(res_carry), .res_zero(res_zero),
      .res_neg(res_neg), .res_ovf(res_ovf),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
      .undef(undef), .busy(busy)
   );

   int nchk = 0;
   int nerr = 0;
   logic [3:0] mflags;   // reference NZCV

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;          4'h1: return !z;
         4'h2: return cy;         4'h3: return !cy;
         4'h4: return n;          4'h5: return !n;
         4'h6: return v;          4'h7: return !v;
         4'h8: return cy && !z;   4'h9: return !cy || z;
         4'hA: return n == v;     4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference outcome of one instruction from the architectural rules.
   task automatic model(input logic [31:0] ins, input logic [3:0] rnzcv,
                        output logic eu, output logic ee, output logic ew,
                        output logic [3:0] enz);
      int op;
      logic cmp;
      op  = int'(ins[24:21]);
      cmp = (op >= 8 && op <= 11);
      eu  = (ins[27:26] != 2'b00) || (!ins[25] && ins[4]) || (COND_EN && ins[31:28] == 4'hF);
      ee  = !eu && (!COND_EN || cond_ok(ins[31:28], mflags));
      ew  = ee && !cmp;
      enz = mflags;
      if (ee && (ins[20] || cmp)) begin
         enz[3:1] = rnzcv[3:1];
         if ((op >= 2 && op <= 7) || op == 10 || op == 11) enz[0] = rnzcv[0];
      end
   endtask

   // Issue one instruction and check every cycle T1..T4 against expectations.
   task automatic run(input logic [31:0] ins, input logic [31:0] rrd, input logic [3:0] rnzcv,
                      input logic eu, input logic ee, input logic ew, input logic [3:0] enz);
      int w = 0;
      while (ifc.instr_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", ifc.instr_ready, 1);
      res_rd = rrd;
      {res_neg, res_zero, res_carry, res_ovf} = rnzcv;
      ifc.instr       = ins;
      ifc.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      ifc.instr       = $urandom;   // accepted word must have been latched
      @(negedge clk);                // T1 DECODE
      chk("t1_undef", undef, eu);
      chk("t1_en", en_inst, 0);
      chk("t1_busy", busy, 1);
      chk("raddr_n", rf_raddr_n, ins[19:16]);
      chk("raddr_m", rf_raddr_m, ins[3:0]);
      @(negedge clk);                // T2 EXEC or back in IDLE
      chk("t2_en", en_inst, ee ? (32'd1 << ins[24:21]) : 32'd0);
      chk("t2_undef", undef, 0);
      chk("t2_ready", ifc.instr_ready, !ee);
      chk("Rn", Rn, rf[ins[19:16]]);
      chk("Rm", Rm, rf[ins[3:0]]);
      chk("imm_fields", {IMM, S, imm_operand, imm_shift, stype},
          {ins[25], ins[20], ins[11:0], ins[11:7], ins[6:5]});
      chk("nzc_in", {neg_in, zero_in, carry_in}, mflags[3:1]);
      chk("t2_flags", {flag_n, flag_z, flag_c, flag_v}, mflags);
      @(negedge clk);                // T3 WB
      chk("t3_we", rf_we, ew);
      chk("t3_en", en_inst, 0);
      if (ew) begin
         chk("waddr", rf_waddr, ins[15:12]);
         chk("wdata", rf_wdata, rrd);
         rf[ins[15:12]] = rrd;
      end
      @(negedge clk);                // T4
      chk("t4_ready", ifc.instr_ready, 1);
      chk("t4_we", rf_we, 0);
      chk("t4_flags", {flag_n, flag_z, flag_c, flag_v}, enz);
      mflags = enz;
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [31:0] rrd;
      logic [3:0]  rnzcv;
      logic        eu, ee, ew;
      logic [3:0]  enz;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ins, rrd;
      logic [3:0]  rn;
      logic        eu, ee, ew;
      logic [3:0]  enz;

      // Hand-derived expectations, applied in order from NZCV=0000.
      tbl[0]  = '{32'hE38210F0, 32'h0000_0FF0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h0};     // ORR r1,r2,#F0
      tbl[1]  = '{32'hE1943225, 32'h0, 4'b0101, 1'b0, 1'b1, 1'b1, 4'b0100};       // ORRS, V kept
      tbl[2]  = '{32'hE3500000, 32'h0, 4'b0011, 1'b0, 1'b1, 1'b0, 4'b0011};       // CMP r0,#0
      tbl[3]  = '{32'h03A00001, 32'h1, 4'b1000, 1'b0, !COND_EN, !COND_EN, 4'b0011}; // MOVEQ, Z=0
      tbl[4]  = '{32'hE0000090, 32'h7, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0011};          // bit4 with I=0
      tbl[5]  = '{32'hE4000000, 32'h7, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0011};          // [27:26]=01
      tbl[6]  = '{32'hF3A00001, 32'h9, 4'b0000, COND_EN, !COND_EN, !COND_EN, 4'b0011}; // cond 1111
      tbl[7]  = '{32'hE0910002, 32'h5, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b1001};       // ADDS
      tbl[8]  = '{32'hE3B00000, 32'h0, 4'b0110, 1'b0, 1'b1, 1'b1, 4'b0111};       // MOVS, V kept
      tbl[9]  = '{32'h13A00002, 32'h2, 4'b0000, 1'b0, !COND_EN, !COND_EN, 4'b0111}; // MOVNE, Z=1
      tbl[10] = '{32'h23A00003, 32'h3, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0111};       // MOVCS, C=1
      tbl[11] = '{32'hE1200000, 32'h0, 4'b1100, 1'b0, 1'b1, 1'b0, 4'b1101};       // TEQ S=0, V kept

      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      rf[2] = 32'h0000_0F00;
      ifc.instr = '0;
      ifc.instr_valid = 1'b0;
      res_rd = '0;
      {res_neg, res_zero, res_carry, res_ovf} = 4'h0;
      mflags = 4'h0;

      // Reset state
      rst = 1'b1;
      #12;
      chk("rst_ready", ifc.instr_ready, 0);
      chk("rst_en", en_inst, 0);
      chk("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
      chk("rst_ctrl", {rf_we, undef, busy}, 0);
      chk("rst_ops", {IMM, S, imm_operand, imm_shift, stype}, 0);
      chk("rst_rn", Rn, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", ifc.instr_ready, 1);
      @(negedge clk);

      for (int i = 0; i < 12; i++)
         run(tbl[i].ins, tbl[i].rrd, tbl[i].rnzcv, tbl[i].eu, tbl[i].ee, tbl[i].ew, tbl[i].enz);

      // Randomized instructions against the reference model
      for (int i = 0; i < 60; i++) begin
         ins = $urandom;
         if ($urandom_range(0, 7) != 0) ins[27:26] = 2'b00;
         if ($urandom_range(0, 3) != 0) ins[4] = 1'b0;
         rrd = $urandom;
         rn  = 4'($urandom);
         model(ins, rn, eu, ee, ew, enz);
         run(ins, rrd, rn, eu, ee, ew, enz);
      end

      // Reset during EXEC: set all flags first, then abort an ORR mid-flight
      run(32'hE3500000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 4'hF);
      ifc.instr = 32'hE38210F0;
      ifc.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("abort_en_before", en_inst, 32'h1000);
      rst = 1'b1;
      #1;
      chk("abort_en", en_inst, 0);
      chk("abort_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
      chk("abort_ready", ifc.instr_ready, 0);
      chk("abort_busy", busy, 0);
      @(posedge clk);
      #1;
      chk("abort_we", rf_we, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready_rel", ifc.instr_ready, 1);
      mflags = 4'h0;
      @(negedge clk);
      run(tbl[0].ins, tbl[0].rrd, tbl[0].rnzcv, tbl[0].eu, tbl[0].ee, tbl[0].ew, tbl[0].enz);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
